// File: rtl/mem_port_arbiter.sv
// Shares one single-ported synchronous memory between IF fetch and M-stage load/store.
// Optional macro ARB_RR_EN: alternate grants when both sides are pending so fetch waits at most one data access.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

    if (WAIT_CYCLES < 1) begin : g_bad_wait
        $error("mem_port_arbiter: WAIT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              pick_data_c;

`ifdef ARB_RR_EN
    logic last_d_q, last_d_d;
    // Yield to a pending fetch right after a data grant.
    assign pick_data_c = d_req & ~(if_req & last_d_q);
`else
    assign pick_data_c = d_req;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
`ifdef ARB_RR_EN
        last_d_d    = last_d_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_data_c) begin
                    state_d     = BUSY_D;
                    cnt_d       = CNT_W'(WAIT_CYCLES);
                    mem_en_d    = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
`ifdef ARB_RR_EN
                    last_d_d    = 1'b1;
`endif
                end else if (if_req) begin
                    state_d    = BUSY_I;
                    cnt_d      = CNT_W'(WAIT_CYCLES);
                    mem_en_d   = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
`ifdef ARB_RR_EN
                    last_d_d   = 1'b0;
`endif
                end
            end
            BUSY_I, BUSY_D: begin
                if (cnt_q > CNT_W'(1)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Last held cycle: capture read data, release the memory, ack next cycle.
                    state_d  = IDLE;
                    cnt_d    = '0;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (state_q == BUSY_I) begin
                        if_rdata_d = mem_rdata;
                        if_ack_d   = 1'b1;
                    end else begin
                        d_ack_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
`ifdef ARB_RR_EN
            last_d_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
`ifdef ARB_RR_EN
            last_d_q    <= last_d_d;
`endif
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign busy      = (state_q != IDLE);
    assign if_stall  = if_req & ~if_ack_q;
    assign d_stall   = d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table plus multi-cycle sequences against a scoreboard
// of expected accesses (ack cycle, memory signals, read data).
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned W      = 2;
    localparam int          P      = int'(W) + 1;

    typedef struct {
        bit                is_d;
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp_rdata;
    } vec_t;

    typedef struct {
        bit                is_d;
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
        int                ack_cyc;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    logic              if_stall;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;
    logic              d_stall;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    exp_t              sb[$];
    vec_t              vt[8];
    int                n_tests;
    int                n_fail;
    int                cyc_n;
    int                c0;
    logic [DATA_W-1:0] exp_ird;
    logic [DATA_W-1:0] exp_drd;
    logic [DATA_W-1:0] mem[1<<ADDR_W];
    bit                mem_ready;

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .WAIT_CYCLES(W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ack   (if_ack),
        .if_stall (if_stall),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_ack    (d_ack),
        .d_stall  (d_stall),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port memory model; contents default to C0DE0000|addr.
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'hC0DE0000 | 32'(i);
            mem[16]   = 32'h2402000A;
            mem_ready = 1'b1;
        end else if (mem_en && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr];

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc_n, act, exp);
        end
    endtask

    task automatic push(input bit is_d, input bit we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] rdata, input int ack_cyc);
        exp_t e;
        e.is_d    = is_d;
        e.we      = we;
        e.addr    = addr;
        e.wdata   = wdata;
        e.rdata   = rdata;
        e.ack_cyc = ack_cyc;
        sb.push_back(e);
    endtask

    task automatic drive(input vec_t v);
        if_req = !v.is_d;
        d_req  = v.is_d;
        if (v.is_d) begin
            d_we    = v.we;
            d_addr  = v.addr;
            d_wdata = v.wdata;
        end else begin
            if_addr = v.addr;
        end
    endtask

    // Compare every output against the scoreboard at the falling edge of the current cycle.
    task automatic sample();
        bit exp_i;
        bit exp_d;
        int ai;
        int ad;
        int ae;
        @(negedge clk);
        exp_i = 1'b0;
        exp_d = 1'b0;
        ai    = -1;
        ad    = -1;
        ae    = -1;
        for (int k = 0; k < sb.size(); k++) begin
            if (sb[k].ack_cyc == cyc_n) begin
                if (sb[k].is_d) begin
                    exp_d = 1'b1;
                    ad    = k;
                end else begin
                    exp_i = 1'b1;
                    ai    = k;
                end
            end
            if (cyc_n >= sb[k].ack_cyc - int'(W) && cyc_n < sb[k].ack_cyc) ae = k;
        end
        if (exp_i) exp_ird = sb[ai].rdata;
        if (exp_d && !sb[ad].we) exp_drd = sb[ad].rdata;
        check("if_ack",   DATA_W'(if_ack),   DATA_W'(exp_i));
        check("d_ack",    DATA_W'(d_ack),    DATA_W'(exp_d));
        check("ack_both", DATA_W'(if_ack & d_ack), '0);
        check("if_stall", DATA_W'(if_stall), DATA_W'(if_req & ~exp_i));
        check("d_stall",  DATA_W'(d_stall),  DATA_W'(d_req & ~exp_d));
        check("mem_en",   DATA_W'(mem_en),   DATA_W'(ae >= 0));
        check("busy",     DATA_W'(busy),     DATA_W'(ae >= 0));
        check("if_rdata", if_rdata, exp_ird);
        check("d_rdata",  d_rdata,  exp_drd);
        if (ae >= 0) begin
            check("mem_addr", DATA_W'(mem_addr), DATA_W'(sb[ae].addr));
            check("mem_we",   DATA_W'(mem_we),   DATA_W'(sb[ae].we));
            if (sb[ae].we) check("mem_wdata", mem_wdata, sb[ae].wdata);
        end
        if (ai > ad) begin
            sb.delete(ai);
            if (ad >= 0) sb.delete(ad);
        end else begin
            if (ad >= 0) sb.delete(ad);
            if (ai >= 0) sb.delete(ai);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic tick();
        sample();
        adv();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d", cyc_n);
        $fatal(1, "timeout");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc_n   = 0;
        exp_ird = '0;
        exp_drd = '0;
        rst_n   = 1'b0;
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;

        vt[0] = '{is_d: 1'b0, we: 1'b0, addr: 10'h010, wdata: 32'h0,        exp_rdata: 32'h2402000A};
        vt[1] = '{is_d: 1'b0, we: 1'b0, addr: 10'h3FF, wdata: 32'h0,        exp_rdata: 32'hC0DE03FF};
        vt[2] = '{is_d: 1'b1, we: 1'b0, addr: 10'h011, wdata: 32'h0,        exp_rdata: 32'hC0DE0011};
        vt[3] = '{is_d: 1'b1, we: 1'b1, addr: 10'h020, wdata: 32'hDEADBEEF, exp_rdata: 32'h0};
        vt[4] = '{is_d: 1'b1, we: 1'b0, addr: 10'h020, wdata: 32'h0,        exp_rdata: 32'hDEADBEEF};
        vt[5] = '{is_d: 1'b1, we: 1'b1, addr: 10'h3FF, wdata: 32'hFFFFFFFF, exp_rdata: 32'h0};
        vt[6] = '{is_d: 1'b0, we: 1'b0, addr: 10'h3FF, wdata: 32'h0,        exp_rdata: 32'hFFFFFFFF};
        vt[7] = '{is_d: 1'b1, we: 1'b0, addr: 10'h000, wdata: 32'h0,        exp_rdata: 32'hC0DE0000};

        // Reset values.
        #12;
        check("rst_mem_en",    DATA_W'(mem_en),    '0);
        check("rst_mem_we",    DATA_W'(mem_we),    '0);
        check("rst_mem_addr",  DATA_W'(mem_addr),  '0);
        check("rst_mem_wdata", mem_wdata,          '0);
        check("rst_if_rdata",  if_rdata,           '0);
        check("rst_d_rdata",   d_rdata,            '0);
        check("rst_if_ack",    DATA_W'(if_ack),    '0);
        check("rst_d_ack",     DATA_W'(d_ack),     '0);
        check("rst_busy",      DATA_W'(busy),      '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Table of single accesses, each next request presented in the previous ack cycle.
        drive(vt[0]);
        for (int i = 0; i < 8; i++) begin
            push(vt[i].is_d, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp_rdata, cyc_n + P);
            repeat (P) tick();
            if (i < 7) drive(vt[i + 1]);
            else begin
                if_req = 1'b0;
                d_req  = 1'b0;
            end
        end
        tick();
        tick();

        // Asynchronous reset in the second held cycle aborts the fetch.
        if_addr = 10'h060;
        if_req  = 1'b1;
        push(1'b0, 1'b0, 10'h060, '0, 32'hC0DE0060, cyc_n + P);
        tick();
        tick();
        #2;
        check("busy_pre_rst", DATA_W'(busy), DATA_W'(1));
        rst_n = 1'b0;
        #1;
        check("abort_mem_en",   DATA_W'(mem_en), '0);
        check("abort_mem_we",   DATA_W'(mem_we), '0);
        check("abort_if_ack",   DATA_W'(if_ack), '0);
        check("abort_d_ack",    DATA_W'(d_ack),  '0);
        check("abort_busy",     DATA_W'(busy),   '0);
        check("abort_if_rdata", if_rdata,        '0);
        check("abort_d_rdata",  d_rdata,         '0);
        sb.delete();
        if_req  = 1'b0;
        exp_ird = '0;
        exp_drd = '0;
        adv();
        adv();
        rst_n = 1'b1;
        repeat (P + 2) tick();

        // Simultaneous requests: the store is served first, then the fetch.
        c0      = cyc_n;
        if_req  = 1'b1;
        if_addr = 10'h010;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 10'h020;
        d_wdata = 32'hDEADBEEF;
        push(1'b1, 1'b1, 10'h020, 32'hDEADBEEF, '0, c0 + P);
        push(1'b0, 1'b0, 10'h010, '0, 32'h2402000A, c0 + 2 * P);
        repeat (P) tick();
        d_req = 1'b0;
        repeat (P) tick();
        if_req = 1'b0;
        tick();
        tick();

        // Fetch dropped and its address changed mid-access: still completes once on the latched address.
        c0      = cyc_n;
        if_req  = 1'b1;
        if_addr = 10'h050;
        push(1'b0, 1'b0, 10'h050, '0, 32'hC0DE0050, c0 + P);
        tick();
        if_req  = 1'b0;
        if_addr = 10'h3FF;
        repeat (P + 3) tick();

        // Both requests held continuously.
        c0      = cyc_n;
        if_req  = 1'b1;
        if_addr = 10'h040;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 10'h030;
        for (int k = 1; k <= 4; k++) begin
`ifdef ARB_RR_EN
            if ((k % 2) == 1) push(1'b1, 1'b0, 10'h030, '0, 32'hC0DE0030, c0 + k * P);
            else              push(1'b0, 1'b0, 10'h040, '0, 32'hC0DE0040, c0 + k * P);
`else
            push(1'b1, 1'b0, 10'h030, '0, 32'hC0DE0030, c0 + k * P);
`endif
        end
        repeat (4 * P) tick();
        if_req = 1'b0;
        d_req  = 1'b0;
        tick();
        tick();

        check("sb_empty", DATA_W'(sb.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
